// File: rtl/mpeg_audio_pkg.sv
// Shared sample/frame types and constants for the MPEG audio output FIFO.
package mpeg_audio_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_CH   = 2;
    localparam int UNDERRUN_W = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t [FRAME_CH-1:0]     frame_t;

    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mpeg_audiofifo_ram.sv
// Simple dual-port frame RAM: one write port, registered read port.
module mpeg_audiofifo_ram #(
    parameter int DEPTH = 128,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Read-first: a same-cycle write to raddr returns the old contents.
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/mpeg_audiofifo_mc.sv
// Multi-channel PCM frame FIFO: serial channel words in, whole frames out (first-word-fall-through).
module mpeg_audiofifo_mc
    import mpeg_audio_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int DEPTH       = 128,
    parameter int CHANNELS    = FRAME_CH,
    parameter int HALF_LEVEL  = 70,
    parameter int FULL_MARGIN = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_write,
    output logic                         in_strobe,
    input  logic [WIDTH-1:0]             in_sample,
    output logic                         out_write,
    input  logic                         out_strobe,
    output logic [CHANNELS*WIDTH-1:0]    out_sample,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         nearly_full,
    output logic                         half_full,
    output logic [UNDERRUN_W-1:0]        underrun_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = CHANNELS*WIDTH;
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS-1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

    logic [CW-1:0] ch_idx;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
    logic [FW-1:0] commit_frame;
    logic [LW-1:0] level_next;
    logic          commit, pop, primed;

    assign in_strobe   = in_write && !reset && !flush && (ch_idx != LAST_CH || level < DEPTH_LVL);
    assign commit      = in_strobe && (ch_idx == LAST_CH);
    assign pop         = out_write && out_strobe;
    assign rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign level_next  = level + LW'(commit) - LW'(pop);

    assign nearly_full = level >= LW'(DEPTH - FULL_MARGIN);
    assign half_full   = level >= LW'(HALF_LEVEL);

    generate
        if (CHANNELS > 1) begin : g_stage
            logic [(CHANNELS-1)*WIDTH-1:0] staging;

            // Leading channels wait here until the last channel completes the frame.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    staging <= '0;
                end else if (in_strobe && !commit) begin
                    for (int c = 0; c < CHANNELS-1; c++)
                        if (ch_idx == CW'(c))
                            staging[c*WIDTH +: WIDTH] <= in_sample;
                end
            end

            assign commit_frame = {in_sample, staging};
        end else begin : g_nostage
            assign commit_frame = in_sample;
        end
    endgenerate

    // A commit landing on the address being read this cycle leaves stale RAM
    // output for one cycle, so out_write is held low until the re-read completes.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ch_idx    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_write <= 1'b0;
            primed    <= 1'b0;
        end else begin
            if (in_strobe)
                ch_idx <= commit ? '0 : ch_idx + 1'b1;
            if (commit)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_ptr_next;
            level     <= level_next;
            out_write <= (level_next != '0) && !(commit && (wr_ptr == rd_ptr_next));
            if (pop)
                primed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            underrun_count <= '0;
        else if (out_strobe && !out_write && primed)
            underrun_count <= sat_inc(underrun_count);
    end

    mpeg_audiofifo_ram #(
        .DEPTH (DEPTH),
        .DW    (FW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .waddr (wr_ptr),
        .wdata (commit_frame),
        .raddr (rd_ptr_next),
        .rdata (out_sample)
    );

endmodule

// File: tb/tb_mpeg_audiofifo_mc.sv
// Self-checking bench for mpeg_audiofifo_mc: frame-queue model plus directed scenarios.
module tb_mpeg_audiofifo_mc;
    import mpeg_audio_pkg::*;

    localparam int WIDTH      = 16;
    localparam int DEPTH      = 128;
    localparam int CHANNELS   = 2;
    localparam int HALF_LEVEL = 70;
    localparam int NF_LEVEL   = DEPTH - 2;
    localparam int LW         = $clog2(DEPTH+1);

    logic                  clk = 1'b0;
    logic                  reset, flush, in_write, in_strobe, out_write, out_strobe;
    logic [WIDTH-1:0]      in_sample;
    logic [CHANNELS*WIDTH-1:0] out_sample;
    logic [LW-1:0]         level;
    logic                  nearly_full, half_full;
    logic [UNDERRUN_W-1:0] underrun_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit check_en = 1'b0;

    typedef struct {
        frame_t data;
        int     cyc;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_stage = '0;
    int          m_ch = 0;
    bit          m_primed = 1'b0;
    int          m_under = 0;
    int          m_pops = 0;

    mpeg_audiofifo_mc dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_write       (in_write),
        .in_strobe      (in_strobe),
        .in_sample      (in_sample),
        .out_write      (out_write),
        .out_strobe     (out_strobe),
        .out_sample     (out_sample),
        .level          (level),
        .nearly_full    (nearly_full),
        .half_full      (half_full),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic [15:0] s, input logic os, input logic fl);
        in_write   = w;
        in_sample  = s;
        out_strobe = os;
        flush      = fl;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushFrame(input logic [15:0] l, input logic [15:0] r);
        in_write = 1'b1; in_sample = l;
        step(1);
        in_sample = r;
        step(1);
        in_write = 1'b0;
    endtask

    // Model: a queue of committed frames; a frame is visible at the output two
    // cycles after the cycle its last word was accepted, once it reaches the head.
    always @(negedge clk) begin
        bit exp_ow, exp_is;
        if (check_en) begin
            exp_ow = (q.size() > 0) && (q[0].cyc <= cyc - 2);
            exp_is = in_write && !reset && !flush && (m_ch != CHANNELS-1 || q.size() < DEPTH);

            checkOutput("out_write", out_write, exp_ow);
            checkOutput("level", level, q.size());
            checkOutput("nearly_full", nearly_full, q.size() >= NF_LEVEL);
            checkOutput("half_full", half_full, q.size() >= HALF_LEVEL);
            checkOutput("in_strobe", in_strobe, exp_is);
            checkOutput("underrun_count", underrun_count, m_under);
            if (exp_ow)
                checkOutput("out_sample", out_sample, q[0].data);

            if (reset) begin
                q.delete();
                m_ch = 0; m_stage = '0; m_primed = 1'b0; m_under = 0;
            end else begin
                if (out_strobe && !exp_ow && m_primed && m_under < 255)
                    m_under++;
                if (flush) begin
                    q.delete();
                    m_ch = 0; m_primed = 1'b0;
                end else begin
                    if (out_strobe && exp_ow) begin
                        void'(q.pop_front());
                        m_primed = 1'b1;
                        m_pops++;
                    end
                    if (exp_is) begin
                        if (m_ch == 0) begin
                            m_stage = in_sample;
                            m_ch    = 1;
                        end else begin
                            q.push_back('{data: {in_sample, m_stage}, cyc: cyc});
                            m_ch = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx, pops_before, budget;
        bit acc;

        reset = 1'b1;
        applyStimulus(1'b1, 16'h0, 1'b0, 1'b0);
        step(2);
        check_en = 1'b1;
        step(1);
        #1;
        checkOutput("rst_level", level, 0);
        checkOutput("rst_out_write", out_write, 0);
        checkOutput("rst_out_sample", out_sample, 0);
        checkOutput("rst_underrun", underrun_count, 0);
        checkOutput("rst_in_strobe", in_strobe, 0);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        step(1);

        // Stereo frame into an empty FIFO: visible exactly two cycles after R accept.
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b1, 16'hABCD, 1'b0, 1'b0);
        #1 checkOutput("r_accept", in_strobe, 1);
        step(1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #1 checkOutput("fwft_n1", out_write, 0);
        step(1);
        #1;
        checkOutput("fwft_n2", out_write, 1);
        checkOutput("frame0", out_sample, 32'hABCD1234);
        checkOutput("level_one", level, 1);
        out_strobe = 1'b1;
        step(1);
        out_strobe = 1'b0;
        #1 checkOutput("empty_after_pop", level, 0);

        // Fill to capacity with threshold boundary checks on the way.
        for (int f = 0; f < DEPTH; f++) begin
            pushFrame(16'(f*2 + 100), 16'(f*2 + 101));
            if (f == 68)  begin #1 checkOutput("half_69", half_full, 0); end
            if (f == 69)  begin #1 checkOutput("half_70", half_full, 1); end
            if (f == 124) begin #1 checkOutput("nf_125", nearly_full, 0); end
            if (f == 125) begin #1 checkOutput("nf_126", nearly_full, 1); end
        end
        #1;
        checkOutput("full_level", level, 128);
        checkOutput("full_nf", nearly_full, 1);
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
        #1 checkOutput("full_l_accept", in_strobe, 1);
        step(1);
        in_sample = 16'h6666;
        #1 checkOutput("full_r_block", in_strobe, 0);
        step(1);
        out_strobe = 1'b1;
        #1 checkOutput("full_r_block2", in_strobe, 0);
        step(1);
        out_strobe = 1'b0;
        #1 checkOutput("r_after_pop", in_strobe, 1);
        step(1);
        in_write = 1'b0;
        #1 checkOutput("refull_level", level, 128);

        // Drain at one frame per cycle.
        out_strobe = 1'b1;
        step(DEPTH);
        out_strobe = 1'b0;
        #1;
        checkOutput("drained_level", level, 0);
        checkOutput("drained_ow", out_write, 0);

        // Sustained push/pop of 1000 frames with an incrementing word pattern.
        idx = 0;
        pops_before = m_pops;
        for (int k = 0; k < 6000 && idx < 2000; k++) begin
            in_write   = 1'b1;
            in_sample  = 16'(idx);
            out_strobe = (k % 4) != 3;
            #1 acc = in_strobe;
            step(1);
            if (acc) idx++;
        end
        in_write = 1'b0;
        out_strobe = 1'b1;
        budget = 0;
        while (q.size() != 0 && budget < 50) begin
            step(1);
            budget++;
        end
        out_strobe = 1'b0;
        checkOutput("sustain_words", idx, 2000);
        checkOutput("sustain_frames", m_pops - pops_before, 1000);
        #1 checkOutput("sustain_level", level, 0);

        // Simultaneous commit and pop at level 70.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #1 checkOutput("reset_clears_underrun", underrun_count, 0);
        for (int f = 0; f < HALF_LEVEL; f++)
            pushFrame(16'(f + 16'h0300), 16'(f + 16'h0400));
        #1;
        checkOutput("level70", level, 70);
        checkOutput("half70", half_full, 1);
        applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b1, 16'h0B0B, 1'b1, 1'b0);
        step(1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        checkOutput("cp_level", level, 70);
        checkOutput("cp_half", half_full, 1);

        // Flush with 40 frames stored and a half-built frame in staging.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        for (int f = 0; f < 40; f++)
            pushFrame(16'(f + 16'h0500), 16'(f + 16'h0600));
        #1 checkOutput("level40", level, 40);
        applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
        step(1);
        applyStimulus(1'b1, 16'h8888, 1'b0, 1'b1);
        #1 checkOutput("flush_block", in_strobe, 0);
        step(1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_level", level, 0);
        checkOutput("flush_ow", out_write, 0);
        pushFrame(16'h1111, 16'h2222);
        #1 checkOutput("post_flush_n1", out_write, 0);
        step(1);
        #1;
        checkOutput("post_flush_ow", out_write, 1);
        checkOutput("post_flush_frame", out_sample, 32'h22221111);

        // Underrun: pop the one frame, then starve the consumer.
        out_strobe = 1'b1;
        step(301);
        out_strobe = 1'b0;
        #1 checkOutput("underrun_sat", underrun_count, 255);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        #1 checkOutput("underrun_after_flush", underrun_count, 255);
        out_strobe = 1'b1;
        step(5);
        out_strobe = 1'b0;
        #1 checkOutput("unprimed_strobes", underrun_count, 255);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        #1 checkOutput("underrun_reset", underrun_count, 0);
        out_strobe = 1'b1;
        step(5);
        out_strobe = 1'b0;
        #1 checkOutput("unprimed_after_reset", underrun_count, 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
